// File: rtl/pwm_sample_conditioner.sv
// pwm_sample_conditioner: DC removal, gain, saturation and frame-paced FIFO release for PWM audio
module pwm_sample_conditioner #(
  parameter int DC_SHIFT   = 6,
  parameter int GAIN_SHIFT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] SampleIn,
  input  logic               SampleValid,
  input  logic               DcBypass,
  output logic signed [11:0] DataOut,
  output logic               FrameTick,
  output logic               Overflow,
  output logic               Underrun
);
  localparam int CW   = $clog2(FRAME_LEN);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int ACCW = 13 + DC_SHIFT;
  localparam int SW   = 13 + GAIN_SHIFT;
  localparam logic signed [SW-1:0] MAXV = SW'(511);
  localparam logic signed [SW-1:0] MINV = -SW'(512);
  logic signed [ACCW-1:0] dc_acc;
  logic signed [12:0]     dc, diff, s1_diff;
  logic signed [SW-1:0]   scaled;
  logic [11:0]            sat, s2_data;
  logic                   s1_valid, s2_valid;
  logic [CW-1:0]          frame_cnt;
  logic [11:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, empty, boundary, pop, wr;
  // datapath arithmetic and FIFO handshake decisions
  always_comb begin
    dc       = 13'(dc_acc >>> DC_SHIFT);
    diff     = DcBypass ? 13'(SampleIn) : 13'(SampleIn) - dc;
    scaled   = SW'(s1_diff) <<< GAIN_SHIFT;
    sat      = scaled > MAXV ? 12'h1ff : scaled < MINV ? 12'he00 : scaled[11:0];
    full     = count == (AW+1)'(FIFO_DEPTH);
    empty    = count == '0;
    boundary = frame_cnt == CW'(FRAME_LEN - 1);
    pop      = boundary && !empty;
    wr       = s2_valid && (!full || pop);
  end
  // FIFO storage; a pop in the same cycle frees the slot the write may land in
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= s2_data;
  // pipeline stages, DC tracker, frame counter, FIFO pointers and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dc_acc    <= '0;
      s1_diff   <= '0;
      s1_valid  <= 1'b0;
      s2_data   <= '0;
      s2_valid  <= 1'b0;
      frame_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DataOut   <= '0;
      FrameTick <= 1'b0;
      Overflow  <= 1'b0;
      Underrun  <= 1'b0;
    end else begin
      s1_valid  <= SampleValid;
      if (SampleValid) s1_diff <= diff;
      if (SampleValid && !DcBypass) dc_acc <= dc_acc + ACCW'(diff);
      s2_valid  <= s1_valid;
      if (s1_valid) s2_data <= sat;
      frame_cnt <= frame_cnt + CW'(1);
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        DataOut <= mem[rd_ptr];
      end
      count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
      FrameTick <= boundary;
      Underrun  <= boundary && empty;
      Overflow  <= s2_valid && full && !pop;
    end
endmodule

// File: tb/tb_pwm_sample_conditioner.sv
// tb_pwm_sample_conditioner: directed and random checks against a queue-based reference model
module tb_pwm_sample_conditioner;
  localparam int FL    = 64;
  localparam int DCS   = 6;
  localparam int GAIN  = 2;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic signed [11:0] SampleIn = '0;
  logic SampleValid = 1'b0, DcBypass = 1'b1;
  logic signed [11:0] DataOut;
  logic FrameTick, Overflow, Underrun;
  typedef struct {int t; int v;} pend_t;
  pend_t pipe[$];
  int fifo[$];
  int ticks[$];
  int unds[$];
  int acc, c, exp_data, ovf_n, vectors, miscompares;
  bit exp_tick, exp_ovf, exp_und;

  pwm_sample_conditioner #(.DC_SHIFT(DCS), .GAIN_SHIFT(GAIN), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .SampleIn(SampleIn), .SampleValid(SampleValid), .DcBypass(DcBypass),
    .DataOut(DataOut), .FrameTick(FrameTick), .Overflow(Overflow), .Underrun(Underrun));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  // conditioned value of one sample: DC tracked as a running average, then gain and clamp
  function automatic int condition(input int s);
    int d, v;
    d = DcBypass ? s : s - (acc >>> DCS);
    if (!DcBypass) acc += d;
    v = d * (1 << GAIN);
    return v > 511 ? 511 : v < -512 ? -512 : v;
  endfunction

  task automatic step();
    int pv;
    bit push;
    pv = 0;
    if (SampleValid) pipe.push_back('{c + 2, condition(int'(SampleIn))});
    push = pipe.size() > 0 && pipe[0].t == c;
    if (push) pv = pipe.pop_front().v;
    exp_tick = (c % FL) == FL - 1;
    exp_und  = exp_tick && fifo.size() == 0;
    if (exp_tick && fifo.size() > 0) exp_data = fifo.pop_front();
    exp_ovf = 1'b0;
    if (push) begin
      if (fifo.size() < DEPTH) fifo.push_back(pv);
      else exp_ovf = 1'b1;
    end
    c++;
    @(posedge clk);
    #1;
    chk("DataOut", DataOut, exp_data);
    chk("FrameTick", FrameTick, exp_tick);
    chk("Overflow", Overflow, exp_ovf);
    chk("Underrun", Underrun, exp_und);
    if (FrameTick) begin
      ticks.push_back(int'(DataOut));
      unds.push_back(int'(Underrun));
    end
    if (Overflow) ovf_n++;
  endtask

  task automatic cyc(input bit v, input int s);
    SampleValid = v;
    SampleIn = 12'(s);
    step();
  endtask

  task automatic wait_to(input int target);
    while (c < target) cyc(1'b0, 0);
  endtask

  task automatic do_reset();
    SampleValid = 1'b0;
    #4;
    rst = 1'b1;
    #1;
    chk("rst_DataOut", DataOut, 0);
    chk("rst_FrameTick", FrameTick, 0);
    chk("rst_Overflow", Overflow, 0);
    chk("rst_Underrun", Underrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pipe.delete();
    fifo.delete();
    ticks.delete();
    unds.delete();
    acc = 0;
    c = 0;
    exp_data = 0;
    ovf_n = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    @(posedge clk);
    #1;
    do_reset();
    // gain and saturation
    DcBypass = 1'b1;
    wait_to(10);
    cyc(1'b1, 100);
    wait_to(74);
    cyc(1'b1, 200);
    wait_to(138);
    cyc(1'b1, -300);
    wait_to(3 * FL + 5);
    chk("gain_ticks", ticks.size(), 3);
    chk("gain_400", ticks[0], 400);
    chk("gain_sat_hi", ticks[1], 511);
    chk("gain_sat_lo", ticks[2], -512);
    // overflow then underrun
    do_reset();
    wait_to(10);
    for (int i = 1; i <= 6; i++) cyc(1'b1, i);
    wait_to(6 * FL + 5);
    chk("ovf_pulses", ovf_n, 2);
    for (int i = 0; i < 4; i++) chk("ovf_order", ticks[i], 4 * (i + 1));
    chk("ovf_no_und", unds[3], 0);
    chk("und5_flag", unds[4], 1);
    chk("und6_flag", unds[5], 1);
    chk("und5_hold", ticks[4], 16);
    chk("und6_hold", ticks[5], 16);
    // push landing on the pop cycle while full
    do_reset();
    wait_to(10);
    for (int i = 7; i <= 10; i++) cyc(1'b1, i);
    wait_to(FL - 3);
    cyc(1'b1, 11);
    wait_to(5 * FL + 5);
    chk("same_no_ovf", ovf_n, 0);
    for (int i = 0; i < 5; i++) chk("same_order", ticks[i], 4 * (i + 7));
    chk("same_no_und", unds[4], 0);
    // reset with queued entries and a sample in flight
    do_reset();
    wait_to(10);
    cyc(1'b1, 50);
    cyc(1'b1, 60);
    cyc(1'b1, 70);
    cyc(1'b1, 80);
    wait_to(70);
    cyc(1'b1, 90);
    chk("pre_rst_data", DataOut, 200);
    do_reset();
    wait_to(FL + 2);
    chk("rst_ticks", ticks.size(), 1);
    chk("rst_tick_data", ticks[0], 0);
    chk("rst_tick_und", unds[0], 1);
    // DC removal
    do_reset();
    DcBypass = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, 1000);
      repeat (7) cyc(1'b0, 0);
    end
    repeat (2 * FL) cyc(1'b0, 0);
    chk("dc_first", ticks[0], 511);
    chk("dc_settled", int'(DataOut) <= 8 && int'(DataOut) >= -8, 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) DcBypass = ~DcBypass;
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 4095)) - 2048);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_sample_conditioner.md
Name: pwm_sample_conditioner

Overview:
- Sits directly upstream of the PWM audio output stage in the 1-bit SDR receive chain.
- Accepts bursty 12-bit signed demodulated samples with a valid strobe and removes DC with a leaky integrator.
- Applies a power-of-two gain, then saturates to the PWM's usable range of -512..511.
- Buffers results in a small FIFO and releases exactly one sample per PWM frame, holding DataOut stable between frames.

Parameters:
- DC_SHIFT, 6: DC tracker time constant, 2^DC_SHIFT samples.
- GAIN_SHIFT, 2: left shift applied after DC removal; legal range 0..4.
- FIFO_DEPTH, 4: sample buffer entries; power of two, at least 2.
- FRAME_LEN, 1024: clocks per PWM frame; power of two, equal to the PWM counter period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- SampleIn  in  12  signed demodulated sample.
- SampleValid  in  1  one-cycle strobe qualifying SampleIn.
- DcBypass  in  1  1 = skip DC removal (diff = SampleIn); the DC accumulator still holds its value.
- DataOut  out  12  signed sample for the PWM DataIn; always within -512..511, sign-extended.
- FrameTick  out  1  one-cycle pulse on the cycle DataOut updates.
- Overflow  out  1  one-cycle pulse when an incoming sample is dropped.
- Underrun  out  1  one-cycle pulse when a frame boundary finds the FIFO empty.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - DataOut = 0, FrameTick = 0, Overflow = 0, Underrun = 0.
  - FIFO pointers (FIFO empty), DC accumulator = 0, frame counter = 0, both pipeline valid bits = 0.
  - Reset mid-frame or mid-pipeline discards all in-flight samples.
- Frame counter:
  - log2(FRAME_LEN) bits, free-running, wraps from FRAME_LEN-1 to 0.
  - The pop decision is made on the cycle the counter equals FRAME_LEN-1.
  - DataOut and FrameTick are registered, so the new value appears on the cycle the counter reads 0.
  - First FrameTick after reset release occurs FRAME_LEN cycles later.
- Stage 1, registered on the cycle after SampleValid:
  - Dc = DcAcc >>> DC_SHIFT. DcAcc width is 12+DC_SHIFT+1, signed.
  - Diff = SampleIn - Dc, 13-bit signed.
  - DcAcc <= DcAcc + Diff, sign-extended; the DC tracker only advances when DcBypass = 0.
  - With DcBypass = 1, Diff = sign-extended SampleIn.
- Stage 2, registered one cycle after stage 1:
  - Scaled = Diff <<< GAIN_SHIFT, computed at full width (13+GAIN_SHIFT) with no wrap.
  - Saturate: values above 511 become 511; values below -512 become -512.
  - The result is written to the FIFO.
  - SampleValid at cycle N gives a FIFO write at N+2; the entry is poppable from N+3.
- FIFO:
  - Push attempted with FIFO full and no pop in the same cycle: the sample is dropped, Overflow pulses for 1 cycle, contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, nothing is dropped, no Overflow.
  - Push and pop in the same cycle while empty: the pop sees empty, so Underrun pulses, DataOut holds and the push is stored.
  - Pop at frame boundary with FIFO not empty: DataOut <= head entry, FrameTick = 1.
  - Pop at frame boundary with FIFO empty: DataOut holds its previous value, FrameTick = 1, Underrun = 1.
- Samples leave in arrival order. Back-to-back SampleValid every cycle is legal.
- DataOut changes only on FrameTick cycles.

Test Plan:
- Gain and saturation:
  - Stimulus: DcBypass=1, GAIN_SHIFT=2; samples 100, 200, -300, one per frame.
  - Required: DataOut = 400, then 511 (0x1FF), then -512 (0xE00) on successive FrameTicks.
- DC removal:
  - Stimulus: DcBypass=0, SampleIn = 1000 constant, one sample per 8 clocks, 2000 samples.
  - Required: first popped value = 511 (saturated); after 2000 samples |DataOut| <= 8.
- Overflow:
  - Stimulus: reset, then 6 back-to-back valid samples 1..6 (bypass, GAIN_SHIFT=0), all arriving mid-frame.
  - Required: Overflow pulses twice; the next 4 FrameTicks give 1, 2, 3, 4.
- Underrun:
  - Stimulus: the Overflow scenario continues with no new samples.
  - Required: the 5th and 6th FrameTicks each assert Underrun and DataOut stays 4.
- Same-cycle boundary:
  - Stimulus: FIFO full (4 entries); a sample's push lands on the pop cycle (counter = FRAME_LEN-1).
  - Required: no Overflow, the head pops, the new sample is stored at the tail, and the count stays 4.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while 3 entries are queued and a sample is in stage 1.
  - Required: all outputs go to 0 immediately (asynchronously); the next FrameTick comes FRAME_LEN cycles after release with Underrun = 1 and DataOut = 0.
